// File: rtl/lfsr_checker.sv
// Serial checker for the 26-bit LFSR pattern: seeds itself from the stream, then flywheels and counts bit errors.
// Optional loss-of-lock/resync window logic is built only when LFSR_CHECKER_RESYNC_EN is defined.
module lfsr_checker #(
  parameter int CNT_W  = 16,
  parameter int WIN    = 64,
  parameter int THRESH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             din,
  input  logic             din_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic {
    SEED,
    CHECK
  } state_t;

  state_t           state, state_nxt;
  logic [25:0]      r, r_nxt;
  logic [4:0]       seed_cnt, seed_cnt_nxt;
  logic             err_pulse_nxt;
  logic [CNT_W-1:0] err_count_nxt;
  logic [25:0]      seed_shift;
  logic             pred;
  logic             mismatch;

  generate
    if (WIN < 32 || WIN > 1024 || (WIN & (WIN - 1)) != 0 || THRESH < 1 || THRESH > WIN)
    begin : g_bad_param
      $error("lfsr_checker: illegal WIN/THRESH combination");
    end
  endgenerate

  assign pred       = r[25] ^ r[5] ^ r[1] ^ r[0];
  assign mismatch   = din ^ pred;
  assign seed_shift = {r[24:0], din};
  assign locked     = (state == CHECK);

`ifdef LFSR_CHECKER_RESYNC_EN
  localparam int BIT_W  = $clog2(WIN);
  localparam int WERR_W = $clog2(WIN + 1);

  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [WERR_W-1:0] win_err, win_err_nxt, win_err_tot;
`endif

  // NOTE: every output of an always_comb gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    state_nxt     = state;
    r_nxt         = r;
    seed_cnt_nxt  = seed_cnt;
    err_pulse_nxt = 1'b0;
    err_count_nxt = err_count;
`ifdef LFSR_CHECKER_RESYNC_EN
    bit_cnt_nxt   = bit_cnt;
    win_err_nxt   = win_err;
    win_err_tot   = win_err;
`endif

    if (clear) begin
      state_nxt     = SEED;
      r_nxt         = '0;
      seed_cnt_nxt  = '0;
      err_count_nxt = '0;
`ifdef LFSR_CHECKER_RESYNC_EN
      bit_cnt_nxt   = '0;
      win_err_nxt   = '0;
`endif
    end else if (din_valid) begin
      unique case (state)
        SEED: begin
          r_nxt = seed_shift;
          if (seed_cnt == 5'd25) begin
            // An all-zero register is the lock-up state: discard it and seed again.
            seed_cnt_nxt = '0;
            if (seed_shift != '0) state_nxt = CHECK;
          end else begin
            seed_cnt_nxt = seed_cnt + 5'd1;
          end
        end

        CHECK: begin
          // Flywheel on the prediction so one flipped bit costs exactly one error.
          r_nxt = {r[24:0], pred};
          if (mismatch) begin
            err_pulse_nxt = 1'b1;
            if (err_count != '1) err_count_nxt = err_count + 1'b1;
          end
`ifdef LFSR_CHECKER_RESYNC_EN
          if (mismatch && win_err != WERR_W'(WIN)) win_err_tot = win_err + 1'b1;
          if (bit_cnt == BIT_W'(WIN - 1)) begin
            bit_cnt_nxt = '0;
            win_err_nxt = '0;
            if (win_err_tot >= WERR_W'(THRESH)) state_nxt = SEED;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
            win_err_nxt = win_err_tot;
          end
`endif
        end

        default: state_nxt = SEED;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEED;
      r         <= '0;
      seed_cnt  <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      r         <= r_nxt;
      seed_cnt  <= seed_cnt_nxt;
      err_pulse <= err_pulse_nxt;
      err_count <= err_count_nxt;
    end
  end

`ifdef LFSR_CHECKER_RESYNC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      win_err <= '0;
    end else begin
      bit_cnt <= bit_cnt_nxt;
      win_err <= win_err_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: expectations are queued as each cycle is driven and compared after the edge.
// Window/resync expectations follow LFSR_CHECKER_RESYNC_EN when it is defined for the build.
module tb_lfsr_checker;

  localparam int CNT_W = 16;
`ifdef LFSR_CHECKER_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             din = 1'b0;
  logic             din_valid = 1'b0;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;

  lfsr_checker #(.CNT_W(CNT_W), .WIN(64), .THRESH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .din       (din),
    .din_valid (din_valid),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             lk;
    logic             ep;
    logic [CNT_W-1:0] ec;
  } exp_t;

  exp_t             sb[$];
  int               n_checks = 0;
  int               n_fail = 0;
  logic [25:0]      g;
  logic             exp_lk = 1'b0;
  logic [CNT_W-1:0] exp_ec = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Drive one cycle; exp_lk/exp_ec already hold the values expected after this edge.
  task automatic step(input string tag, input logic v, input logic b, input logic ep);
    exp_t e;
    din       = b;
    din_valid = v;
    sb.push_back('{lk: exp_lk, ep: ep, ec: exp_ec});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".locked"}, 32'(locked), 32'(e.lk));
    check({tag, ".err_pulse"}, 32'(err_pulse), 32'(e.ep));
    check({tag, ".err_count"}, 32'(err_count), 32'(e.ec));
  endtask

  function automatic logic gen_next();
    logic nb;
    nb = g[25] ^ g[5] ^ g[1] ^ g[0];
    g  = {g[24:0], nb};
    return nb;
  endfunction

  task automatic send_gen(input string tag, input logic flip);
    logic b;
    b = gen_next();
    if (flip) exp_ec = exp_ec + 1'b1;
    step(tag, 1'b1, b ^ flip, flip);
  endtask

  task automatic gap(input string tag);
    step(tag, 1'b0, 1'($urandom), 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".locked"}, 32'(locked), 32'd0);
    check({tag, ".err_pulse"}, 32'(err_pulse), 32'd0);
    check({tag, ".err_count"}, 32'(err_count), 32'd0);
  endtask

  task automatic seed_ones(input string tag);
    for (int j = 0; j < 26; j++) begin
      exp_lk = (j == 25);
      step(tag, 1'b1, 1'b1, 1'b0);
    end
    g = '1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // Seed with ones; the first predicted bit is 0.
    seed_ones("seed");
    send_gen("first_bit", 1'b0);

    // Clean stream with random valid gaps.
    begin
      int nv = 0;
      while (nv < 1000) begin
        if ($urandom_range(0, 3) == 0) gap("clean_gap");
        else begin
          send_gen("clean", 1'b0);
          nv++;
        end
      end
    end

    // Single inverted bit: one pulse, no propagation.
    for (int i = 0; i < 150; i++) send_gen("single", i == 99);

    // Four more spaced errors bring err_count to 5.
    for (int i = 0; i < 100; i++) send_gen("more_err", (i % 25) == 10);
    check("count_five", 32'(err_count), 32'd5);

    // Clear wins over a simultaneous valid bit.
    clear  = 1'b1;
    exp_lk = 1'b0;
    exp_ec = '0;
    step("clear", 1'b1, gen_next(), 1'b0);
    clear  = 1'b0;

    // All-zero seed is rejected; lock comes after the 52nd bit.
    for (int j = 0; j < 26; j++) step("zero_seed", 1'b1, 1'b0, 1'b0);
    seed_ones("one_seed");

    // Eight errors inside the first window after lock.
    for (int k = 0; k < 64; k++) begin
      if (RESYNC && k == 63) exp_lk = 1'b0;
      send_gen("window", k >= 10 && k <= 24 && (k % 2) == 0);
    end
    check("window_count", 32'(err_count), 32'd8);
    for (int j = 0; j < 26; j++) begin
      if (RESYNC) exp_lk = (j == 25);
      send_gen("relock", 1'b0);
    end
    for (int j = 0; j < 40; j++) begin
      if (j % 5 == 2) gap("post_relock_gap");
      send_gen("post_relock", 1'b0);
    end

    // Asynchronous reset while locked with a nonzero count.
    #1 rst_n = 1'b0;
    #1 check_zero("reset_locked");
    exp_lk = 1'b0;
    exp_ec = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Asynchronous reset in the middle of seeding restarts the seed count.
    for (int j = 0; j < 10; j++) step("mid_seed", 1'b1, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #1 check_zero("reset_mid_seed");
    @(posedge clk);
    #1 rst_n = 1'b1;
    seed_ones("reseed");
    for (int j = 0; j < 30; j++) send_gen("post_reset", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
